// File: rtl/seq_det_pkg.sv
// Shared types, default pattern constants and the overlap-aware match-length functions
// used by the serial pattern scheduler.
package seq_det_pkg;

    localparam int         MAX_PAT_LEN = 8;
    localparam int         DEF_PAT_LEN = 4;
    localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;

    typedef logic [$clog2(DEF_PAT_LEN+1)-1:0] ctx_t;

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input logic [7:0] pat, input int len, input int i);
        if (i < 0 || i >= len)
            return 1'b0;
        return pat[3'(len - 1 - i)];
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border_len(input logic [7:0] pat, input int len);
        int   best = 0;
        logic ok;
        for (int j = 1; j < MAX_PAT_LEN; j++) begin
            if (j < len) begin
                ok = 1'b1;
                for (int m = 0; m < MAX_PAT_LEN; m++)
                    if (m < j && pat_bit(pat, len, m) != pat_bit(pat, len, len - j + m))
                        ok = 1'b0;
                if (ok)
                    best = j;
            end
        end
        return best;
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, b).
    function automatic int next_len(input logic [7:0] pat, input int len,
                                    input int k_in, input logic b);
        int          k;
        int          best = 0;
        logic        ok;
        logic [15:0] s;
        k = (k_in >= len) ? border_len(pat, len) : k_in;
        s = '0;
        for (int i = 0; i <= MAX_PAT_LEN; i++)
            s[4'(i)] = (i < k) ? pat_bit(pat, len, i) : ((i == k) ? b : 1'b0);
        for (int j = 1; j <= MAX_PAT_LEN; j++) begin
            if (j <= k + 1 && j <= len) begin
                ok = 1'b1;
                for (int m = 0; m < MAX_PAT_LEN; m++)
                    if (m < j && s[4'(k + 1 - j + m)] != pat_bit(pat, len, m))
                        ok = 1'b0;
                if (ok)
                    best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_match_engine.sv
// Combinational match step shared by every channel: saved match length plus one bit
// gives the next match length and a hit flag when the full pattern has been seen.
module seq_match_engine
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
    parameter int                 CTX_W   = $clog2(PAT_LEN+1)
) (
    input  logic [CTX_W-1:0] ctx_in,
    input  logic             bit_in,
    output logic [CTX_W-1:0] ctx_out,
    output logic             hit
);

    always_comb begin
        ctx_out = CTX_W'(next_len(8'(PATTERN), PAT_LEN, int'(ctx_in), bit_in));
        hit     = (ctx_out == CTX_W'(PAT_LEN));
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one pattern match engine across NUM_CH serial streams.
// Define SEQ_DET_SCHED_CNT_EN to add saturating per-channel hit counters (rd_ch/rd_count).
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int                 NUM_CH  = 4,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
    localparam int                CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_valid,
    input  logic [NUM_CH-1:0] ch_bit,
    output logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_clear,
    output logic              det_valid,
    output logic [CH_W-1:0]   det_ch
`ifdef SEQ_DET_SCHED_CNT_EN
    ,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [7:0]        rd_count
`endif
);

    localparam int CTX_W = $clog2(PAT_LEN+1);

    logic [CTX_W-1:0]  ctx [NUM_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [NUM_CH-1:0] eligible;
    logic [CH_W-1:0]   gidx;
    logic              any_grant;
    logic [CTX_W-1:0]  eng_ctx;
    logic              eng_hit;

    // Handshake: a bit moves when ch_valid[i] & ch_ready[i]; a clear on the same
    // channel masks its request, so a clearing channel is never granted.
    assign eligible = ch_valid & ~ch_clear;

    always_comb begin
        int idx;
        idx       = 0;
        ch_ready  = '0;
        gidx      = '0;
        any_grant = 1'b0;
        for (int o = 0; o < NUM_CH; o++) begin
            idx = (int'(rr_ptr) + o) % NUM_CH;
            if (!any_grant && eligible[idx]) begin
                any_grant     = 1'b1;
                ch_ready[idx] = 1'b1;
                gidx          = CH_W'(idx);
            end
        end
    end

    seq_match_engine #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .CTX_W   (CTX_W)
    ) u_engine (
        .ctx_in  (ctx[gidx]),
        .bit_in  (ch_bit[gidx]),
        .ctx_out (eng_ctx),
        .hit     (eng_hit)
    );

`ifdef SEQ_DET_SCHED_CNT_EN
    logic [7:0] cnt [NUM_CH];
    assign rd_count = cnt[rd_ch];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx[i] <= '0;
`ifdef SEQ_DET_SCHED_CNT_EN
                cnt[i] <= '0;
`endif
            end
            rr_ptr    <= '0;
            det_valid <= 1'b0;
            det_ch    <= '0;
        end else begin
            det_valid <= any_grant && eng_hit;
            if (any_grant) begin
                ctx[gidx] <= eng_ctx;
                rr_ptr    <= (gidx == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(gidx + 1'b1);
                if (eng_hit) begin
                    det_ch <= gidx;
`ifdef SEQ_DET_SCHED_CNT_EN
                    if (cnt[gidx] != 8'hFF)
                        cnt[gidx] <= cnt[gidx] + 8'd1;
`endif
                end
            end
            // Granted channels are never clearing, so these never collide with the update above.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_clear[i]) begin
                    ctx[i] <= '0;
`ifdef SEQ_DET_SCHED_CNT_EN
                    cnt[i] <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler: overlap detection, round-robin order, masking,
// clear and mid-stream reset; counter saturation when SEQ_DET_SCHED_CNT_EN is defined.
module tb_seq_det_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] ch_valid;
    logic [3:0] ch_bit;
    logic [3:0] ch_ready;
    logic [3:0] ch_clear;
    logic       det_valid;
    logic [1:0] det_ch;
`ifdef SEQ_DET_SCHED_CNT_EN
    logic [1:0] rd_ch;
    logic [7:0] rd_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];
    logic [3:0] pat_bits = 4'b1011;

    seq_det_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .ch_valid  (ch_valid),
        .ch_bit    (ch_bit),
        .ch_ready  (ch_ready),
        .ch_clear  (ch_clear),
        .det_valid (det_valid),
        .det_ch    (det_ch)
`ifdef SEQ_DET_SCHED_CNT_EN
        ,
        .rd_ch     (rd_ch),
        .rd_count  (rd_count)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        ch_valid = '0;
        ch_bit   = '0;
        ch_clear = '0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drive one cycle of inputs, check the grant before the edge and the detection after it.
    task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] exp_rdy, input logic exp_det,
                         input logic [1:0] exp_ch, input string tag);
        ch_valid = v;
        ch_bit   = b;
        ch_clear = c;
        #2;
        check({tag, "_rdy"}, 32'(ch_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check({tag, "_det"}, 32'(det_valid), 32'(exp_det));
        if (exp_det)
            check({tag, "_ch"}, 32'(det_ch), 32'(exp_ch));
    endtask

    initial begin
        logic [1:0] chan;
        logic       bt;
        logic       ed;
        reset    = 1'b1;
        ch_valid = '0;
        ch_bit   = '0;
        ch_clear = '0;
`ifdef SEQ_DET_SCHED_CNT_EN
        rd_ch    = '0;
`endif
        @(posedge clk);
        do_reset();
        check("rst_det_valid", 32'(det_valid), 32'd0);
        check("rst_det_ch", 32'(det_ch), 32'd0);
        #2;
        check("rst_ready", 32'(ch_ready), 32'd0);

        // ch0 alone: 1,0,1,1,0,1,1 -> hits after 4th and 7th bits
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "s0_b1");
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, "s0_b2");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "s0_b3");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "s0_b4");
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, "s0_b5");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "s0_b6");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "s0_b7");
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "idle");

        // All four channels valid: rotating grants, hits on consecutive cycles
        do_reset();
        for (int q = 0; q < 4; q++)
            exp_q.push_back(2'(q));
        for (int r = 0; r < 4; r++) begin
            bt = pat_bits[2'(3 - r)];
            for (int g = 0; g < 4; g++) begin
                ed   = (r == 3);
                chan = ed ? exp_q.pop_front() : 2'd0;
                drive(4'b1111, {4{bt}}, 4'b0000, 4'(1 << g), ed, chan, "rr");
            end
        end
        drive(4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0, "rr_wrap");

        // ch0 preloaded with 1,0,1; ch1/ch3 alternate; ch0 and ch2 contexts must survive
        do_reset();
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "m_p1");
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, "m_p2");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "m_p3");
        for (int r = 0; r < 4; r++) begin
            bt = pat_bits[2'(3 - r)];
            ed = (r == 3);
            drive(4'b1010, {4{bt}}, 4'b0000, 4'b0010, ed, 2'd1, "m_c1");
            drive(4'b1010, {4{bt}}, 4'b0000, 4'b1000, ed, 2'd3, "m_c3");
        end
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "m_ch0_keep");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "m_ch2_b1");
        drive(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0, "m_ch2_b2");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "m_ch2_b3");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, "m_ch2_b4");

        // ch2 partial 1,0,1 then clear alongside valid: no grant, full pattern needed again
        do_reset();
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "c_p1");
        drive(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0, "c_p2");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "c_p3");
        drive(4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0, "c_clr");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "c_b1");
        drive(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0, "c_b2");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "c_b3");
        drive(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2, "c_b4");

        // Reset mid-stream while ch0 offers the completing bit
        do_reset();
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "r_p1");
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, "r_p2");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "r_p3");
        ch_valid = 4'b0001;
        ch_bit   = 4'b0001;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("r_rst_det", 32'(det_valid), 32'd0);
        drive(4'b1111, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "r_b1");
        drive(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, "r_b2");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "r_b3");
        drive(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "r_b4");

`ifdef SEQ_DET_SCHED_CNT_EN
        // 300 overlapping hits on ch1 saturate its counter; clear zeroes it
        do_reset();
        rd_ch = 2'd1;
        drive(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0, "k_b1");
        drive(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, "k_b2");
        drive(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0, "k_b3");
        drive(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, "k_b4");
        #1;
        check("k_cnt1", 32'(rd_count), 32'd1);
        ch_valid = 4'b0010;
        for (int n = 0; n < 299; n++) begin
            ch_bit = 4'b0000; @(posedge clk); #1;
            ch_bit = 4'b0010; @(posedge clk); #1;
            ch_bit = 4'b0010; @(posedge clk); #1;
        end
        ch_valid = 4'b0000;
        #1;
        check("k_sat", 32'(rd_count), 32'd255);
        rd_ch = 2'd0;
        #1;
        check("k_ch0", 32'(rd_count), 32'd0);
        rd_ch = 2'd1;
        drive(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, "k_clr");
        check("k_cleared", 32'(rd_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
